// File: rtl/switch_input_capture.sv
// Push-button/slide-switch front end: synchronize, debounce accept, capture the switch word per press.
// Optional auto-repeat while held: define SWITCH_INPUT_CAPTURE_AUTO_REPEAT_EN.
//
// state     | meaning
// RELEASED  | debounced button is up, waiting for a press
// PRESSED   | debounced button is down, first capture done
// REPEATING | held past the repeat delay, capturing every repeat period
module switch_input_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        accept,
  input  logic [15:0] switch,
  input  logic        consume,
  output logic [15:0] data,
  output logic        valid,
  output logic        accept_pulse,
  output logic        overrun
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESSED, REPEATING} state_t;

  logic        acc_meta_q, acc_sync_q;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic        db_q;
  logic [CW-1:0] db_cnt_q;
  state_t      state_q;
  logic [15:0] data_q;
  logic        valid_q, pulse_q, ovr_q;

  logic mismatch_d, db_flip_d, db_rise_d, db_fall_d, rpt_hit_d, capture_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_meta_q <= 1'b0;
      acc_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      acc_meta_q <= accept;
      acc_sync_q <= acc_meta_q;
      sw_meta_q  <= switch;
      sw_sync_q  <= sw_meta_q;
      if (!mismatch_d || db_flip_d) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (db_flip_d) db_q <= acc_sync_q;
    end
  end

  assign mismatch_d = (acc_sync_q != db_q);
  assign db_flip_d  = mismatch_d && (db_cnt_q == CNT_LAST);
  assign db_rise_d  = db_flip_d && acc_sync_q;
  assign db_fall_d  = db_flip_d && !acc_sync_q;

`ifdef SWITCH_INPUT_CAPTURE_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q;

  assign rpt_hit_d = ((state_q == PRESSED) && (rpt_q == DELAY_LAST)) ||
                     ((state_q == REPEATING) && (rpt_q == PERIOD_LAST));

  // Counter restarts on every repeat capture so REPEATING spaces captures by REPEAT_PERIOD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else if ((state_q == RELEASED) || db_fall_d || rpt_hit_d) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_q + 1'b1;
    end
  end
`else
  assign rpt_hit_d = 1'b0;
`endif

  assign capture_d = db_rise_d || (rpt_hit_d && !db_fall_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pulse_q <= capture_d;
      if (capture_d) begin
        data_q  <= sw_sync_q;
        valid_q <= 1'b1;
        if (valid_q && !consume) ovr_q <= 1'b1;
      end else if (consume && valid_q) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        RELEASED:  if (db_rise_d) state_q <= PRESSED;
        PRESSED: begin
          if (db_fall_d)      state_q <= RELEASED;
          else if (rpt_hit_d) state_q <= REPEATING;
        end
        REPEATING: if (db_fall_d) state_q <= RELEASED;
        default:   state_q <= RELEASED;
      endcase
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign accept_pulse = pulse_q;
  assign overrun      = ovr_q;

endmodule
